// File: rtl/rs544522_pkg.sv
// Shared constants, types and GF(2^10) helpers for the RS(544,522) syndrome block.
// Holds the code geometry (W, R, L, N, BEATS), the primitive polynomial and the
// constant-multiplier tables used by every syndrome cell.
package rs544522_pkg;

  localparam int unsigned W     = 10;
  localparam int unsigned R     = 22;
  localparam int unsigned L     = 8;
  localparam int unsigned N     = 544;
  localparam int unsigned BEATS = N / L;
  localparam int unsigned CNT_W = 7;

  // x^10 + x^3 + 1
  localparam logic [W:0] PRIM_POLY = 11'h409;

  typedef logic [W-1:0]          sym_t;
  typedef logic [2*W-2:0]        prod_t;
  typedef sym_t [L-1:0]          blk_t;
  typedef sym_t [R-1:0]          synd_t;
  typedef sym_t [0:R-1]          pow8_tbl_t;
  typedef sym_t [0:R-1][0:L-1]   powij_tbl_t;

  // Polynomial-basis multiply: carry-less product, then fold the top W-1 bits back.
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    prod_t p;
    p = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (b[i]) p = p ^ (prod_t'(a) << i);
    end
    for (int k = 2 * W - 2; k >= int'(W); k--) begin
      if (p[k]) p = p ^ (prod_t'(PRIM_POLY) << (k - int'(W)));
    end
    return p[W-1:0];
  endfunction

  // Row i, lane j holds alpha^(i*(7-j)); built by repeated multiplication by alpha^i.
  function automatic powij_tbl_t gen_pow_ij();
    powij_tbl_t t;
    sym_t       step;
    sym_t       e;
    t    = '0;
    step = sym_t'(1);
    for (int unsigned i = 0; i < R; i++) begin
      e = sym_t'(1);
      for (int unsigned k = 0; k < L; k++) begin
        t[i][L-1-k] = e;
        e = gf_mul(e, step);
      end
      step = gf_mul(step, sym_t'(2));
    end
    return t;
  endfunction

  // Entry i holds alpha^(8i) = (alpha^i)^L.
  function automatic pow8_tbl_t gen_pow_8i();
    pow8_tbl_t t;
    sym_t      step;
    sym_t      e;
    t    = '0;
    step = sym_t'(1);
    for (int unsigned i = 0; i < R; i++) begin
      e = sym_t'(1);
      for (int unsigned k = 0; k < L; k++) e = gf_mul(e, step);
      t[i] = e;
      step = gf_mul(step, sym_t'(2));
    end
    return t;
  endfunction

  localparam pow8_tbl_t  ALPHA_POW_8I = gen_pow_8i();
  localparam powij_tbl_t ALPHA_POW_IJ = gen_pow_ij();

endpackage

// File: rtl/rs544522_synd_l8_if.sv
// Stream interface of the syndrome block: symbol input beats plus the held result.
// slave  : view of the syndrome calculator (consumes beats, produces the result)
// master : view of the surrounding logic (produces beats, consumes the result)
interface rs544522_synd_l8_if;
  import rs544522_pkg::*;

  logic  valid_i;
  logic  ready_o;
  logic  last_i;
  blk_t  r_blk_i;
  logic  synd_valid_o;
  logic  synd_ready_i;
  synd_t synd_o;
  logic  zero_o;
  logic  len_err_o;

  modport slave (
    input  valid_i, last_i, r_blk_i, synd_ready_i,
    output ready_o, synd_valid_o, synd_o, zero_o, len_err_o
  );

  modport master (
    output valid_i, last_i, r_blk_i, synd_ready_i,
    input  ready_o, synd_valid_o, synd_o, zero_o, len_err_o
  );
endinterface

// File: rtl/gf1024_mul_pb_k5_flat.sv
// Flat combinational GF(2^10) multiplier in polynomial basis (x^10+x^3+1).
// Tying one operand to a constant lets synthesis reduce it to an XOR network.
// a_i, b_i : operands    p_o : product
module gf1024_mul_pb_k5_flat
  import rs544522_pkg::*;
(
  input  sym_t a_i,
  input  sym_t b_i,
  output sym_t p_o
);
  assign p_o = gf_mul(a_i, b_i);
endmodule

// File: rtl/rs544522_synd_cell.sv
// One syndrome accumulator S_I: A <= A*alpha^(8I) ^ sum_j d_j*alpha^(I*(7-j)).
// clk_i, rst_i : clock, synchronous active-high reset
// en_i         : beat accepted this cycle
// first_i      : beat starts a codeword (prior accumulator treated as zero)
// blk_i        : eight received symbols, lane 0 highest degree
// acc_d_o      : updated accumulator value (next-state), used for result capture
module rs544522_synd_cell
  import rs544522_pkg::*;
#(
  parameter int unsigned I = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic first_i,
  input  blk_t blk_i,
  output sym_t acc_d_o
);
  sym_t           acc_q, acc_d;
  sym_t           fb_prod;
  sym_t [L-1:0]   lane_prod;

  gf1024_mul_pb_k5_flat u_mul_fb (
    .a_i (acc_q),
    .b_i (ALPHA_POW_8I[I]),
    .p_o (fb_prod)
  );

  for (genvar j = 0; j < L; j++) begin : g_lane
    gf1024_mul_pb_k5_flat u_mul_lane (
      .a_i (blk_i[j]),
      .b_i (ALPHA_POW_IJ[I][j]),
      .p_o (lane_prod[j])
    );
  end

  always_comb begin
    acc_d = first_i ? '0 : fb_prod;
    for (int unsigned j = 0; j < L; j++) acc_d = acc_d ^ lane_prod[j];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_d_o = acc_d;
endmodule

// File: rtl/rs544522_synd_l8.sv
// RS(544,522) syndrome calculator, 8 symbols per beat, 22 syndromes.
// clk_i : clock          rst_i : synchronous active-high reset
// bus   : beat input (valid/ready/last/r_blk) and held result
//         (synd_valid/synd_ready/synd/zero/len_err)
module rs544522_synd_l8
  import rs544522_pkg::*;
(
  input logic              clk_i,
  input logic              rst_i,
  rs544522_synd_l8_if.slave bus
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last, close_cand, ready, accept, closing, consume;
  synd_t            acc_d;
  synd_t            synd_q;
  logic             synd_valid_q, zero_q, len_err_q;

  // Only a full result buffer with no consumer stalls, and only the closing beat
  // actually needs the buffer; non-closing beats flow regardless.
  assign ready      = !(synd_valid_q && !bus.synd_ready_i);
  assign cnt_last   = (cnt_q == CNT_W'(BEATS - 1));
  assign close_cand = bus.last_i || cnt_last;
  assign accept     = bus.valid_i && (ready || !close_cand);
  assign closing    = accept && close_cand;
  assign consume    = synd_valid_q && bus.synd_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = closing ? '0 : cnt_q + CNT_W'(1);
  end

  for (genvar i = 0; i < R; i++) begin : g_cell
    rs544522_synd_cell #(.I(i)) u_cell (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (accept),
      .first_i (cnt_q == '0),
      .blk_i   (bus.r_blk_i),
      .acc_d_o (acc_d[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      synd_q       <= '0;
      synd_valid_q <= 1'b0;
      zero_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (closing) begin
        synd_q       <= acc_d;
        zero_q       <= (acc_d == '0);
        len_err_q    <= !(bus.last_i && cnt_last);
        synd_valid_q <= 1'b1;
      end else if (consume) begin
        synd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o      = ready;
  assign bus.synd_valid_o = synd_valid_q;
  assign bus.synd_o       = synd_q;
  assign bus.zero_o       = zero_q;
  assign bus.len_err_o    = len_err_q;
endmodule

// File: tb/tb_rs544522_synd_l8.sv
// Directed bench for rs544522_synd_l8. Expected syndromes come from bench-side
// log/antilog GF tables and a bench-side systematic RS(544,522) encoder.
module tb_rs544522_synd_l8;
  import rs544522_pkg::*;

  localparam int SW = R * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs544522_synd_l8_if bus ();

  rs544522_synd_l8 dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [9:0]  alog [0:1022];
  int          lg   [0:1023];
  logic [9:0]  cw   [0:543];
  logic [9:0]  g    [0:22];
  logic [9:0]  rem  [0:21];
  synd_t       exp_a;

  function automatic logic [9:0] mul(input logic [9:0] a, input logic [9:0] b);
    if (a == 10'd0 || b == 10'd0) return 10'd0;
    return alog[(lg[a] + lg[b]) % 1023];
  endfunction

  // Syndromes of a word that is zero except r_0 = v0 and r_543 = v543.
  function automatic synd_t exp_single(input logic [9:0] v0, input logic [9:0] v543);
    synd_t s;
    for (int i = 0; i < R; i++) s[i] = v0 ^ mul(v543, alog[(543 * i) % 1023]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input synd_t s, input logic z, input logic le);
    chk({tag, ".valid"},   SW'(bus.synd_valid_o), SW'(1'b1));
    chk({tag, ".synd"},    bus.synd_o,            s);
    chk({tag, ".zero"},    SW'(bus.zero_o),       SW'(z));
    chk({tag, ".len_err"}, SW'(bus.len_err_o),    SW'(le));
    if (bus.synd_ready_i) begin
      @(negedge clk);
      chk({tag, ".consumed"}, SW'(bus.synd_valid_o), SW'(1'b0));
    end
  endtask

  task automatic clr_cw();
    for (int k = 0; k < 544; k++) cw[k] = 10'd0;
  endtask

  task automatic drive_beat(input int b, input logic last);
    bus.valid_i = 1'b1;
    bus.last_i  = last;
    for (int j = 0; j < L; j++) bus.r_blk_i[j] = cw[543 - 8 * b - j];
  endtask

  // Beats 0..nb-1 of cw; last_i on beat last_at (-1: never); optional idle gaps
  // carrying junk on last_i/r_blk_i.
  task automatic send(input int nb, input int last_at, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      if (gaps) begin
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b1;
        for (int j = 0; j < L; j++) bus.r_blk_i[j] = 10'($urandom);
        @(negedge clk);
      end
      drive_beat(b, b == last_at);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
  endtask

  initial begin
    begin : tables
      int a;
      a = 1;
      for (int k = 0; k < 1023; k++) begin
        alog[k] = 10'(a);
        lg[a]   = k;
        a = a << 1;
        if ((a & 1024) != 0) a = a ^ 'h409;
      end
    end

    rst              = 1'b1;
    bus.valid_i      = 1'b0;
    bus.last_i       = 1'b0;
    bus.r_blk_i      = '0;
    bus.synd_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.valid",   SW'(bus.synd_valid_o), SW'(1'b0));
    chk("rst.zero",    SW'(bus.zero_o),       SW'(1'b0));
    chk("rst.len_err", SW'(bus.len_err_o),    SW'(1'b0));
    chk("rst.synd",    bus.synd_o,            '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", SW'(bus.ready_o), SW'(1'b1));

    // All-zero codeword; result must not appear before the closing beat is taken
    clr_cw();
    send(68, 67, 1'b0);
    chk("zero.early", SW'(bus.synd_valid_o), SW'(1'b0));
    idle();
    chk_res("zero", '0, 1'b1, 1'b0);

    // Encoded codeword, message m_k = k mod 1024 at coefficient 22+k
    for (int t = 0; t < 23; t++) g[t] = 10'd0;
    g[0] = 10'd1;
    for (int i = 0; i < R; i++) begin
      for (int t = 22; t >= 1; t--) g[t] = g[t-1] ^ mul(g[t], alog[i]);
      g[0] = mul(g[0], alog[i]);
    end
    for (int k = 0; k < 522; k++) cw[22 + k] = 10'(k % 1024);
    for (int t = 0; t < 22; t++) rem[t] = 10'd0;
    for (int k = 521; k >= 0; k--) begin
      logic [9:0] fb;
      fb = cw[22 + k] ^ rem[21];
      for (int t = 21; t >= 1; t--) rem[t] = rem[t-1] ^ mul(fb, g[t]);
      rem[0] = mul(fb, g[0]);
    end
    for (int t = 0; t < 22; t++) cw[t] = rem[t];
    send(68, 67, 1'b0);
    idle();
    chk_res("enc", '0, 1'b1, 1'b0);

    // Single error r_0 = 5
    clr_cw();
    cw[0] = 10'd5;
    send(68, 67, 1'b0);
    idle();
    chk_res("r0", exp_single(10'd5, 10'd0), 1'b0, 1'b0);

    // Single error r_543 = 1
    clr_cw();
    cw[543] = 10'd1;
    send(68, 67, 1'b0);
    idle();
    chk_res("r543", exp_single(10'd0, 10'd1), 1'b0, 1'b0);

    // Same word with idle gaps carrying junk
    send(68, 67, 1'b1);
    idle();
    chk_res("gaps", exp_single(10'd0, 10'd1), 1'b0, 1'b0);

    // Short codeword: last_i on beat 40; last received symbol (coeff 216) = 5
    clr_cw();
    cw[216] = 10'd5;
    send(41, 40, 1'b0);
    idle();
    chk_res("short", exp_single(10'd5, 10'd0), 1'b0, 1'b1);

    // Following codeword must start at counter 0
    clr_cw();
    cw[543] = 10'd1;
    send(68, 67, 1'b0);
    idle();
    chk_res("after_short", exp_single(10'd0, 10'd1), 1'b0, 1'b0);

    // 68 beats without last_i close on count alone
    clr_cw();
    cw[0] = 10'd5;
    send(68, -1, 1'b0);
    idle();
    chk_res("nolast", exp_single(10'd5, 10'd0), 1'b0, 1'b1);

    // Back-to-back with consumer stalled
    bus.synd_ready_i = 1'b0;
    exp_a = exp_single(10'd5, 10'd0);
    send(68, 67, 1'b0);
    chk("bp.ready_a", SW'(bus.ready_o), SW'(1'b1));
    idle();
    chk_res("bp.a", exp_a, 1'b0, 1'b0);
    chk("bp.ready_held", SW'(bus.ready_o), SW'(1'b0));
    clr_cw();
    cw[543] = 10'd1;
    send(67, -1, 1'b0);
    @(negedge clk);
    drive_beat(67, 1'b1);
    chk("bp.ready_close", SW'(bus.ready_o), SW'(1'b0));
    repeat (10) @(negedge clk);
    chk("bp.a_held", bus.synd_o, exp_a);
    chk("bp.a_valid", SW'(bus.synd_valid_o), SW'(1'b1));
    bus.synd_ready_i = 1'b1;
    idle();
    chk_res("bp.b", exp_single(10'd0, 10'd1), 1'b0, 1'b0);

    // Reset mid-codeword at beat 30, then clean double-position word
    for (int k = 0; k < 544; k++) cw[k] = 10'($urandom);
    send(30, -1, 1'b0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.valid", SW'(bus.synd_valid_o), SW'(1'b0));
    chk("mrst.synd",  bus.synd_o,            '0);
    clr_cw();
    cw[0]   = 10'd5;
    cw[543] = 10'd1;
    send(68, 67, 1'b0);
    chk("mrst.no_stale", SW'(bus.synd_valid_o), SW'(1'b0));
    idle();
    chk_res("mrst", exp_single(10'd5, 10'd1), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs544522_synd_l8.md
RS544522_SYND_L8 -- requirements
Module: rs544522_synd_l8

Interface
REQ-001 Parameters SHALL be W=10 (symbol width), R=22 (syndrome count), L=8 (lanes per beat), N=544 (codeword symbols), BEATS=68 (N/L).
REQ-002 Port clk_i SHALL be an input, 1 bit wide, and is the single clock; every flop samples on its rising edge.
REQ-003 Port rst_i SHALL be an input, 1 bit wide, and is the reset: synchronous and active-high.
REQ-004 Port valid_i SHALL be an input, 1 bit wide, and qualifies an input beat.
REQ-005 Port ready_o SHALL be an output, 1 bit wide; a beat is accepted when valid_i and ready_o are both 1.
REQ-006 Port last_i SHALL be an input, 1 bit wide, and marks the final beat of a codeword.
REQ-007 Port r_blk_i SHALL be an input of L x W bits carrying the received symbols; lane 0 is the highest-degree coefficient.
REQ-008 Port synd_valid_o SHALL be an output, 1 bit wide, and indicates that the syndrome result is held.
REQ-009 Port synd_ready_i SHALL be an input, 1 bit wide; the result is consumed when synd_valid_o and synd_ready_i are both 1.
REQ-010 Port synd_o SHALL be an output of R x W bits; entry i holds S_i.
REQ-011 Port zero_o SHALL be an output, 1 bit wide, and is 1 when all 22 syndromes are zero.
REQ-012 Port len_err_o SHALL be an output, 1 bit wide, and is 1 when the codeword's beat count was not 68.

Function
REQ-013 Symbol order SHALL be: beat b, lane j carries coefficient r_(543-8b-j); beat 0, lane 0 is r_543.
REQ-014 Arithmetic SHALL be GF(2^10) with primitive polynomial x^10+x^3+1 and alpha=2; syndrome S_i = r(alpha^i) for i=0..21.
REQ-015 On each accepted beat, each accumulator SHALL update as A_i <= A_i*alpha^(8i) XOR sum over j=0..7 of d_j*alpha^(i*(7-j)); all multipliers are constant multipliers.
REQ-016 On the first beat of a codeword, the accumulator's prior value SHALL be treated as zero; the first accepted beat after reset or after a closing beat starts a codeword.
REQ-017 A 7-bit beat counter SHALL count 0..67 and return to 0 on every closing beat.
REQ-018 A closing beat SHALL be an accepted beat with last_i=1 or with counter=67.
REQ-019 On a closing beat, len_err SHALL be set to NOT(last_i AND counter==67).
REQ-020 On a closing beat, the updated accumulator value SHALL be loaded into the output register, and synd_valid_o SHALL be 1 in the next cycle (latency 1 cycle after the last beat).
REQ-021 zero_o and len_err_o SHALL be registered together with synd_o and held stable while synd_valid_o=1.
REQ-022 synd_valid_o SHALL clear in the cycle after a consume unless a new closing beat loads the register in that same cycle; simultaneous consume and load SHALL yield the new result with synd_valid_o remaining 1.
REQ-023 ready_o SHALL equal NOT(synd_valid_o AND NOT synd_ready_i) and SHALL be combinational from synd_ready_i only; it is never combinational from valid_i.
REQ-024 Non-closing beats SHALL be accepted regardless of output-buffer state; only this term gates ready_o.
REQ-025 Cycles with valid_i=0 SHALL leave the accumulator and counter unchanged; gaps within a codeword are allowed.
REQ-026 When valid_i=0, last_i and r_blk_i SHALL be ignored.

Reset
REQ-027 While rst_i=1, the accumulator and counter SHALL be 0, and synd_valid_o, zero_o and len_err_o SHALL be 0.
REQ-028 While rst_i=1, synd_o SHALL be all-zero.
REQ-029 A reset mid-codeword SHALL discard the partial codeword, and the first beat after rst_i deasserts starts a new codeword.
REQ-030 ready_o SHALL be 1 in the first cycle after reset.

Structure
REQ-031 Package rs544522_pkg SHALL hold W, R, L, N, BEATS, the primitive polynomial, and the constant tables ALPHA_POW_8I[0:21] and ALPHA_POW_IJ[0:21][0:7].
REQ-032 Sub-module rs544522_synd_cell SHALL implement one syndrome's accumulator update (parameter I), instantiated R times; constant multiplication SHALL reuse gf1024_mul_pb_k5_flat.
REQ-033 The design SHALL use no multicycle paths: one GF multiply plus a 9-input XOR tree per cycle.

Verification
REQ-034 Scenario: 68 beats of all-zero symbols, last_i on beat 67 -> synd_valid_o=1 one cycle later, all S_i=0, zero_o=1, len_err_o=0.
REQ-035 Scenario: a codeword produced by the team's RS(544,522) encoder (message m_k = k mod 1024) -> all S_i=0, zero_o=1.
REQ-036 Scenario: all-zero codeword except beat 67, lane 7 (r_0) = 5 -> every S_i=5, zero_o=0; except beat 0, lane 0 (r_543) = 1 -> S_i = alpha^(543*i mod 1023).
REQ-037 Scenario: two back-to-back codewords with synd_ready_i=0 for 10 cycles -> ready_o drops only at the second closing beat, the first result is held unchanged, and the second result appears one cycle after release.
REQ-038 Scenario: last_i on beat 40 -> result output with len_err_o=1, the next beat restarts at counter 0; 68 beats without last_i -> closes at beat 67 with len_err_o=1.
REQ-039 Scenario: rst_i for 1 cycle mid-codeword at beat 30, then a clean zero-plus-single-error codeword -> the correct syndromes are output and no stale output appears.
